// File: rtl/ct_combine_if.sv
// Valid/ready stream bundle carrying a data word and an end-of-frame marker.
// "in" and "out" are the consumer and producer views. "slave" and "master" are the same views under their usual names.
interface axis_if #(
  parameter int W = 8
) ();
  logic         vld;
  logic         rdy;
  logic         last;
  logic [W-1:0] data;

  modport in     (input vld, data, last, output rdy);
  modport out    (output vld, data, last, input rdy);
  modport slave  (input vld, data, last, output rdy);
  modport master (output vld, data, last, input rdy);
endinterface

// File: rtl/ct_combine.sv
// Ciphertext combiner: c = (z + e + m[0]*DELTA) mod Q over a two-stage stallable pipeline.
// Polynomial framing on c is regenerated from a local coefficient counter.
module ct_combine #(
  parameter int              N     = 16,
  parameter int              QW    = 64,
  parameter int              UW    = 1,
  parameter logic [QW-1:0]   Q     = QW'(64'hFFFF_FFFF_0000_0001),
  parameter logic [QW-1:0]   DELTA = Q >> 1
) (
  input  logic clk,
  input  logic s_rst_n,
  axis_if.in   z,
  axis_if.in   e,
  axis_if.in   m,
  axis_if.out  c,
  output logic err
);
  localparam int          CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [QW:0] QX = {1'b0, Q};
  localparam logic [QW:0] DX = {1'b0, DELTA};

  logic          s1_vld_reg, s1_m_reg, s1_last_reg;
  logic [QW-1:0] s1_data_reg;
  logic          s2_vld_reg, s2_last_reg;
  logic [QW-1:0] s2_data_reg;
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  logic          stall, accept, cnt_at_last, frame_err;
  logic [QW:0]   sum1, fold1, sum2, fold2;
  logic [2:0]    last_in, last_mis;

  assign stall  = s2_vld_reg & ~c.rdy;
  // The reset term keeps every rdy low while s_rst_n is asserted, even with all vld high.
  assign accept = s_rst_n & z.vld & e.vld & m.vld & ~stall;

  assign z.rdy = accept;
  assign e.rdy = accept;
  assign m.rdy = accept;

  assign cnt_at_last = (cnt_reg == CW'(N - 1));

  assign last_in = {m.last, e.last, z.last};
  for (genvar gi = 0; gi < 3; gi++) begin : g_frame
    assign last_mis[gi] = last_in[gi] ^ cnt_at_last;
  end
  assign frame_err = |last_mis;

  // Both operands are already reduced, so one conditional subtract per stage is enough.
  always_comb begin
    sum1  = {1'b0, z.data} + {1'b0, e.data};
    fold1 = (sum1 >= QX) ? (sum1 - QX) : sum1;
    sum2  = {1'b0, s1_data_reg} + (s1_m_reg ? DX : '0);
    fold2 = (sum2 >= QX) ? (sum2 - QX) : sum2;
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_vld_reg  <= 1'b0;
      s1_m_reg    <= 1'b0;
      s1_last_reg <= 1'b0;
      s1_data_reg <= '0;
      s2_vld_reg  <= 1'b0;
      s2_last_reg <= 1'b0;
      s2_data_reg <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      // A stall freezes the whole pipe so the beat parked on c is never lost or repeated.
      if (!stall) begin
        s1_vld_reg  <= accept;
        s1_m_reg    <= m.data[0];
        s1_last_reg <= cnt_at_last;
        s1_data_reg <= fold1[QW-1:0];
        s2_vld_reg  <= s1_vld_reg;
        s2_last_reg <= s1_last_reg;
        s2_data_reg <= fold2[QW-1:0];
      end
      if (accept) begin
        cnt_reg <= cnt_at_last ? '0 : cnt_reg + CW'(1);
        if (frame_err) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign c.vld  = s2_vld_reg;
  assign c.data = s2_data_reg;
  assign c.last = s2_last_reg;
  assign err    = err_reg;
endmodule

// File: tb/tb_ct_combine.sv
// Directed bench for ct_combine with N=4, QW=8, Q=97, DELTA=48.
// The bench drives inputs 1 ns after the rising edge and samples on the falling edge.
module tb_ct_combine;
  logic clk = 1'b0;
  logic s_rst_n = 1'b0;
  logic err;
  int   vec_cnt = 0;
  int   miss_cnt = 0;

  always #5 clk = ~clk;

  axis_if #(.W(8)) z_if ();
  axis_if #(.W(8)) e_if ();
  axis_if #(.W(1)) m_if ();
  axis_if #(.W(8)) c_if ();

  ct_combine #(.N(4), .QW(8), .UW(1), .Q(8'd97), .DELTA(8'd48)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .z(z_if), .e(e_if), .m(m_if), .c(c_if), .err(err)
  );

  // Beats for the stall test, with hand-reduced results.
  logic [7:0] st_z [8] = '{8'd10, 8'd90, 8'd40, 8'd96, 8'd5,  8'd50, 8'd0,  8'd60};
  logic [7:0] st_e [8] = '{8'd20, 8'd10, 8'd40, 8'd1,  8'd5,  8'd50, 8'd96, 8'd0};
  logic       st_m [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
  logic [7:0] st_c [8] = '{8'd30, 8'd3,  8'd31, 8'd48, 8'd10, 8'd51, 8'd96, 8'd11};

  task automatic drive_beat(input logic v, input logic [7:0] zd, input logic [7:0] ed,
                            input logic md, input logic lst);
    z_if.vld = v; e_if.vld = v; m_if.vld = v;
    z_if.data = zd; e_if.data = ed; m_if.data = md;
    z_if.last = lst; e_if.last = lst; m_if.last = lst;
  endtask

  task automatic test_reset();
    drive_beat(1'b1, 8'd5, 8'd6, 1'b1, 1'b0);
    c_if.rdy = 1'b1;
    s_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (c_if.vld !== 1'b0) begin miss_cnt++; $display("FAIL reset_c_vld got %0b want 0", c_if.vld); end
    vec_cnt++; if (c_if.last !== 1'b0) begin miss_cnt++; $display("FAIL reset_c_last got %0b want 0", c_if.last); end
    vec_cnt++; if (c_if.data !== 8'd0) begin miss_cnt++; $display("FAIL reset_c_data got %0d want 0", c_if.data); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err got %0b want 0", err); end
    vec_cnt++; if (z_if.rdy !== 1'b0) begin miss_cnt++; $display("FAIL reset_z_rdy got %0b want 0", z_if.rdy); end
    vec_cnt++; if (e_if.rdy !== 1'b0) begin miss_cnt++; $display("FAIL reset_e_rdy got %0b want 0", e_if.rdy); end
    vec_cnt++; if (m_if.rdy !== 1'b0) begin miss_cnt++; $display("FAIL reset_m_rdy got %0b want 0", m_if.rdy); end
    drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    s_rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] bz [4] = '{8'd50, 8'd96, 8'd0, 8'd1};
    logic [7:0] be [4] = '{8'd60, 8'd96, 8'd0, 8'd2};
    logic       bm [4] = '{1'b1,  1'b1,  1'b0, 1'b0};
    logic [7:0] bc [4] = '{8'd61, 8'd46, 8'd0, 8'd3};
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, bz[i], be[i], bm[i], (i == 3));
      @(negedge clk);
      vec_cnt++; if (z_if.rdy !== 1'b1) begin miss_cnt++; $display("FAIL basic_rdy[%0d] got %0b want 1", i, z_if.rdy); end
      @(posedge clk); #1;
      drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      vec_cnt++; if (c_if.vld !== 1'b0) begin miss_cnt++; $display("FAIL basic_early_vld[%0d] got %0b want 0", i, c_if.vld); end
      @(posedge clk); #1;
      vec_cnt++; if (c_if.vld !== 1'b1) begin miss_cnt++; $display("FAIL basic_vld[%0d] got %0b want 1", i, c_if.vld); end
      vec_cnt++; if (c_if.data !== bc[i]) begin miss_cnt++; $display("FAIL basic_data[%0d] got %0d want %0d", i, c_if.data, bc[i]); end
      vec_cnt++; if (c_if.last !== (i == 3)) begin miss_cnt++; $display("FAIL basic_last[%0d] got %0b want %0b", i, c_if.last, (i == 3)); end
      $display("basic beat %0d: z=%0d e=%0d m=%0b -> c=%0d", i, bz[i], be[i], bm[i], c_if.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int in_i = 0, out_i = 0, cyc = 0, stall_cyc = 0;
    logic held_v = 1'b0;
    logic [7:0] held = 8'd0;
    c_if.rdy = 1'b1;
    drive_beat(1'b1, st_z[0], st_e[0], st_m[0], 1'b0);
    while (out_i < 8 && cyc < 60) begin
      @(negedge clk);
      if (c_if.vld && !c_if.rdy) begin
        stall_cyc++;
        vec_cnt++; if ((z_if.rdy | e_if.rdy | m_if.rdy) !== 1'b0) begin miss_cnt++; $display("FAIL stall_rdy cyc %0d got %0b want 0", cyc, z_if.rdy | e_if.rdy | m_if.rdy); end
        if (held_v) begin
          vec_cnt++; if (c_if.data !== held) begin miss_cnt++; $display("FAIL stall_hold cyc %0d got %0d want %0d", cyc, c_if.data, held); end
        end
        held = c_if.data; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (z_if.vld && z_if.rdy) in_i++;
      if (c_if.vld && c_if.rdy) begin
        vec_cnt++; if (c_if.data !== st_c[out_i]) begin miss_cnt++; $display("FAIL stall_data[%0d] got %0d want %0d", out_i, c_if.data, st_c[out_i]); end
        vec_cnt++; if (c_if.last !== (out_i % 4 == 3)) begin miss_cnt++; $display("FAIL stall_last[%0d] got %0b want %0b", out_i, c_if.last, (out_i % 4 == 3)); end
        $display("stall out %0d: c=%0d last=%0b", out_i, c_if.data, c_if.last);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (in_i < 8) drive_beat(1'b1, st_z[in_i], st_e[in_i], st_m[in_i], (in_i % 4 == 3));
      else drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      c_if.rdy = !(cyc >= 5 && cyc < 8);
    end
    vec_cnt++; if (out_i !== 8) begin miss_cnt++; $display("FAIL stall_count got %0d want 8", out_i); end
    vec_cnt++; if (stall_cyc !== 3) begin miss_cnt++; $display("FAIL stall_cycles got %0d want 3", stall_cyc); end
    repeat (3) @(negedge clk);
    vec_cnt++; if (c_if.vld !== 1'b0) begin miss_cnt++; $display("FAIL stall_dup got vld %0b want 0", c_if.vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_vld_gap();
    logic [7:0] gz [4] = '{8'd20, 8'd7, 8'd90, 8'd0};
    logic [7:0] ge [4] = '{8'd30, 8'd8, 8'd90, 8'd0};
    logic       gm [4] = '{1'b1,  1'b0, 1'b0,  1'b1};
    logic [7:0] gc [4] = '{8'd1,  8'd15, 8'd83, 8'd48};
    int in_i = 0, out_i = 0, cyc = 0;
    c_if.rdy = 1'b1;
    drive_beat(1'b1, gz[0], ge[0], gm[0], 1'b0);
    e_if.vld = 1'b0;
    while (out_i < 4 && cyc < 40) begin
      @(negedge clk);
      if (cyc < 2) begin
        vec_cnt++; if ((z_if.rdy | e_if.rdy | m_if.rdy) !== 1'b0) begin miss_cnt++; $display("FAIL gap_rdy cyc %0d got %0b want 0", cyc, z_if.rdy | e_if.rdy | m_if.rdy); end
      end
      if (z_if.vld && z_if.rdy) begin
        if (in_i == 0) begin
          vec_cnt++; if (cyc !== 2) begin miss_cnt++; $display("FAIL gap_first_accept got cyc %0d want 2", cyc); end
        end
        in_i++;
      end
      if (c_if.vld && c_if.rdy) begin
        vec_cnt++; if (c_if.data !== gc[out_i]) begin miss_cnt++; $display("FAIL gap_data[%0d] got %0d want %0d", out_i, c_if.data, gc[out_i]); end
        vec_cnt++; if (c_if.last !== (out_i == 3)) begin miss_cnt++; $display("FAIL gap_last[%0d] got %0b want %0b", out_i, c_if.last, (out_i == 3)); end
        $display("gap out %0d: c=%0d last=%0b", out_i, c_if.data, c_if.last);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (in_i < 4) drive_beat(1'b1, gz[in_i], ge[in_i], gm[in_i], (in_i == 3));
      else drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      if (cyc < 2) e_if.vld = 1'b0;
    end
    vec_cnt++; if (out_i !== 4) begin miss_cnt++; $display("FAIL gap_count got %0d want 4", out_i); end
  endtask

  task automatic test_err();
    int in_i = 0, out_i = 0, cyc = 0;
    c_if.rdy = 1'b1;
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL err_initial got %0b want 0", err); end
    drive_beat(1'b1, 8'd0, 8'd1, 1'b0, 1'b0);
    while (out_i < 4 && cyc < 40) begin
      @(negedge clk);
      vec_cnt++; if (err !== (in_i >= 2)) begin miss_cnt++; $display("FAIL err_flag cyc %0d got %0b want %0b", cyc, err, (in_i >= 2)); end
      if (z_if.vld && z_if.rdy) in_i++;
      if (c_if.vld && c_if.rdy) begin
        vec_cnt++; if (c_if.data !== 8'(out_i + 1)) begin miss_cnt++; $display("FAIL err_data[%0d] got %0d want %0d", out_i, c_if.data, out_i + 1); end
        vec_cnt++; if (c_if.last !== (out_i == 3)) begin miss_cnt++; $display("FAIL err_last[%0d] got %0b want %0b", out_i, c_if.last, (out_i == 3)); end
        $display("err out %0d: c=%0d last=%0b err=%0b", out_i, c_if.data, c_if.last, err);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (in_i < 4) begin
        drive_beat(1'b1, 8'(in_i), 8'd1, 1'b0, (in_i == 3));
        z_if.last = (in_i == 1) || (in_i == 3);
      end else begin
        drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      end
    end
    vec_cnt++; if (out_i !== 4) begin miss_cnt++; $display("FAIL err_count got %0d want 4", out_i); end
    repeat (3) @(negedge clk);
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL err_sticky got %0b want 1", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int in_i = 0, out_i = 0, cyc = 0;
    c_if.rdy = 1'b1;
    drive_beat(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    while (out_i < 8 && cyc < 40) begin
      @(negedge clk);
      if (in_i < 8) begin
        vec_cnt++; if (z_if.rdy !== 1'b1) begin miss_cnt++; $display("FAIL b2b_rdy[%0d] got %0b want 1", in_i, z_if.rdy); end
      end
      if (out_i > 0 && out_i < 8) begin
        vec_cnt++; if (c_if.vld !== 1'b1) begin miss_cnt++; $display("FAIL b2b_gap before out %0d got vld %0b want 1", out_i, c_if.vld); end
      end
      if (z_if.vld && z_if.rdy) in_i++;
      if (c_if.vld && c_if.rdy) begin
        vec_cnt++; if (c_if.data !== 8'(13 * out_i)) begin miss_cnt++; $display("FAIL b2b_data[%0d] got %0d want %0d", out_i, c_if.data, 13 * out_i); end
        vec_cnt++; if (c_if.last !== (out_i % 4 == 3)) begin miss_cnt++; $display("FAIL b2b_last[%0d] got %0b want %0b", out_i, c_if.last, (out_i % 4 == 3)); end
        $display("b2b out %0d: c=%0d last=%0b", out_i, c_if.data, c_if.last);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (in_i < 8) drive_beat(1'b1, 8'(12 * in_i), 8'(in_i), 1'b0, (in_i % 4 == 3));
      else drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    end
    vec_cnt++; if (out_i !== 8) begin miss_cnt++; $display("FAIL b2b_count got %0d want 8", out_i); end
  endtask

  task automatic test_async_reset();
    int in_i = 0, out_i = 0, cyc = 0;
    c_if.rdy = 1'b1;
    drive_beat(1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    while (in_i < 3 && cyc < 20) begin
      @(negedge clk);
      if (z_if.vld && z_if.rdy) in_i++;
      @(posedge clk); #1;
      cyc++;
      drive_beat(1'b1, 8'(in_i + 1), 8'd0, 1'b0, 1'b0);
    end
    vec_cnt++; if (c_if.vld !== 1'b1) begin miss_cnt++; $display("FAIL arst_inflight got vld %0b want 1", c_if.vld); end
    #2 s_rst_n = 1'b0;
    #1;
    vec_cnt++; if (c_if.vld !== 1'b0) begin miss_cnt++; $display("FAIL arst_c_vld got %0b want 0", c_if.vld); end
    vec_cnt++; if (c_if.data !== 8'd0) begin miss_cnt++; $display("FAIL arst_c_data got %0d want 0", c_if.data); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL arst_err got %0b want 0", err); end
    vec_cnt++; if (z_if.rdy !== 1'b0) begin miss_cnt++; $display("FAIL arst_rdy got %0b want 0", z_if.rdy); end
    $display("async reset asserted mid-polynomial: c.vld=%0b", c_if.vld);
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1'b1;
    in_i = 0; cyc = 0;
    drive_beat(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    while (out_i < 4 && cyc < 40) begin
      @(negedge clk);
      if (z_if.vld && z_if.rdy) in_i++;
      if (c_if.vld && c_if.rdy) begin
        vec_cnt++; if (c_if.data !== 8'(out_i)) begin miss_cnt++; $display("FAIL arst_data[%0d] got %0d want %0d", out_i, c_if.data, out_i); end
        vec_cnt++; if (c_if.last !== (out_i == 3)) begin miss_cnt++; $display("FAIL arst_last[%0d] got %0b want %0b", out_i, c_if.last, (out_i == 3)); end
        $display("post-reset out %0d: c=%0d last=%0b", out_i, c_if.data, c_if.last);
        out_i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (in_i < 4) drive_beat(1'b1, 8'(in_i), 8'd0, 1'b0, (in_i == 3));
      else drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    end
    vec_cnt++; if (out_i !== 4) begin miss_cnt++; $display("FAIL arst_count got %0d want 4", out_i); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL arst_err_after got %0b want 0", err); end
  endtask

  initial begin
    c_if.rdy = 1'b0;
    drive_beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_stall();
    test_vld_gap();
    test_err();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/ct_combine.md
CT_COMBINE -- requirements
Module: ct_combine

Interface
REQ-001 The module SHALL have parameter N, default 16, meaning coefficients per polynomial.
REQ-002 The module SHALL have parameter QW, default 64, meaning coefficient bit-width.
REQ-003 The module SHALL have parameter UW, default 1, meaning message-coefficient bit-width.
REQ-004 The module SHALL have parameter Q, default 64'hFFFF_FFFF_0000_0001, meaning modulus, with 2 <= Q < 2^QW.
REQ-005 The module SHALL have parameter DELTA, default Q/2, meaning message scaling factor, with DELTA < Q.
REQ-006 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-007 Port s_rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port z, axis_if.in, QW: product coefficients in [0,Q) from the upstream polynomial multiplier.
REQ-009 Port e, axis_if.in, QW: noise coefficients in [0,Q).
REQ-010 Port m, axis_if.in, UW: message coefficients; only bit 0 is used.
REQ-011 Port c, axis_if.out, QW: ciphertext coefficients c = (z + e + m[0]*DELTA) mod Q.
REQ-012 Port err, output, 1: sticky framing-error flag.

Function
REQ-013 A beat is accepted only when z.vld, e.vld and m.vld are all 1 and stall is 0, where stall = c.vld & !c.rdy.
REQ-014 z.rdy, e.rdy and m.rdy SHALL all equal that same accept term, so the three streams are consumed together or not at all.
REQ-015 Pipeline is 2 register stages:
  - S1: s1 = z+e, computed at QW+1 bits, minus Q if the sum >= Q.
  - S2: s2 = s1 + (m[0] ? DELTA : 0), computed at QW+1 bits, minus Q if the sum >= Q.
  - S2 drives c.data directly.
REQ-016 Latency SHALL be 2 cycles: an input accepted at edge k appears on c at edge k+2 when there is no stall.
REQ-017 Each stage carries a valid bit; a bubble from missing input vld propagates as a stage valid of 0.
REQ-018 When stall is 1, both stages SHALL hold data, valid and last unchanged, so no beat is lost or duplicated.
REQ-019 c.vld SHALL equal the S2 valid bit; c.data and c.last SHALL remain stable while c.vld=1 and c.rdy=0.
REQ-020 A coefficient counter SHALL run 0..N-1, incrementing on each accept and wrapping N-1 -> 0.
REQ-021 c.last SHALL be generated from counter == N-1 at accept time and pipelined with the data; it does not copy any input last.
REQ-022 On each accept, err SHALL set if any of z.last, e.last, m.last differs from (counter == N-1).
REQ-023 err SHALL remain set until reset; processing continues unaffected.
REQ-024 Any number of back-to-back polynomials SHALL stream with no idle cycle between them; throughput is 1 coefficient/cycle.
REQ-025 Only reset can clear the counter mid-polynomial; there is no other abort.

Reset
REQ-026 While s_rst_n=0, outputs SHALL be: c.vld=0, c.last=0, c.data=0, err=0, all input rdy=0; the counter and both stage valid bits are 0.
REQ-027 Reset assertion SHALL take effect without a clock edge, discarding any in-flight beats.
REQ-028 After reset release, the first accepted beat is coefficient 0 of a new polynomial.

Verification (N=4, QW=8, Q=97, DELTA=48)
REQ-029 z=50, e=60, m=1, c.rdy=1 -> c.data=61 exactly 2 cycles after accept.
REQ-030 z=96, e=96, m=1 -> c.data=46; z=0, e=0, m=0 -> c.data=0.
REQ-031 Stream 8 beats with c.rdy held low for 3 cycles mid-stream -> input rdy is 0 during the stall, all 8 results are in order and unduplicated, and c.last is set on beats 3 and 7.
REQ-032 z.vld and m.vld are 1 but e.vld is 0 for 2 cycles -> no rdy and no accept; z/m data are consumed only once e.vld rises.
REQ-033 z.last=1 on beat 1 of 4 -> err=1 from the next cycle and stays 1; c.last still occurs on beat 3.
REQ-034 Assert s_rst_n=0 asynchronously after beat 2 of 4 -> c.vld drops immediately; after release, the next beat produces a c.last 4 beats later.
